// File: rtl/boot_memory_unit.sv
// ---------------------------------------------------------------------------
// boot_memory_unit
//
// Word-addressed 32-bit boot RAM. After every reset release it copies a
// fixed BIOS image into the bottom BIOS_WORDS words, one word per clock.
// It then opens a host port with chip select, write enable and output
// enable, all active-low. A free-standing PC incrementer shares the block.
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   : once boot is done, a host access with Address[1:0] != 0 is
//               dropped and err pulses high for one cycle
//   undefined : Address[1:0] is ignored and err is tied low
//
// Ports
//   clock      in   single clock, rising edge
//   reset      in   synchronous reset, active-high
//   Address    in   [31:0] host byte address; word index Address[AW+1:2]
//   data_in    in   [31:0] host write data
//   data_out   out  [31:0] registered read data, holds between reads
//   CS         in   chip select, active-low
//   WE         in   write enable, active-low; wins over OE
//   OE         in   read enable, active-low
//   rd_valid   out  one-cycle pulse: data_out was loaded by the last edge
//   boot_done  out  BIOS copy finished, host port live
//   pc_in      in   [31:0] adder operand
//   pc_next    out  [31:0] pc_in + 4, combinational
//   err        out  misaligned-access pulse (see macro above)
// ---------------------------------------------------------------------------
// State table
//   state   | meaning
//   ST_BOOT | copying BIOS word boot_cnt_q each cycle; host port ignored
//   ST_LIVE | copy complete, boot_done high, host reads/writes accepted
// ---------------------------------------------------------------------------
module boot_memory_unit #(
   parameter int ADDR_WIDTH = 8,
   parameter int BIOS_WORDS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic        CS,
   input  logic        WE,
   input  logic        OE,
   output logic        rd_valid,
   output logic        boot_done,
   input  logic [31:0] pc_in,
   output logic [31:0] pc_next,
   output logic        err
);

   localparam int             DEPTH     = 1 << ADDR_WIDTH;
   localparam int             CW        = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]  CNT_END   = CW'(BIOS_WORDS);
   localparam logic [31:0]    BIOS_BASE = 32'hB105_0000;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_LIVE = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           boot_cnt_q, boot_cnt_d;
   logic [31:0]             data_out_q, data_out_d;
   logic                    rd_valid_q, rd_valid_d;

   logic [31:0]             mem [DEPTH];
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [31:0]             mem_wdata;

   logic [ADDR_WIDTH-1:0]   host_idx;
   logic                    host_req;
   logic                    misaligned;
   logic                    unused_addr;

   // Upper address bits alias by design; only the word index is decoded.
   assign host_idx    = Address[ADDR_WIDTH+1:2];
   assign host_req    = ~CS & (~WE | ~OE);
   assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

`ifdef MISALIGN_CHECK_EN
   logic err_q, err_d;
   assign misaligned = |Address[1:0];
   assign err        = err_q;
`else
   assign misaligned = 1'b0;
   assign err        = 1'b0;
`endif

   assign pc_next   = pc_in + 32'd4;
   assign data_out  = data_out_q;
   assign rd_valid  = rd_valid_q;
   assign boot_done = (state_q == ST_LIVE);

   // ---------------- next-state / datapath control ----------------
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = host_idx;
      mem_wdata  = data_in;
`ifdef MISALIGN_CHECK_EN
      err_d      = 1'b0;
`endif

      case (state_q)
         ST_BOOT: begin
            // The counter runs one past the last word so that boot_done
            // rises on the edge after the final copy write, not with it.
            if (boot_cnt_q == CNT_END) begin
               state_d = ST_LIVE;
            end else begin
               mem_we     = 1'b1;
               mem_addr   = boot_cnt_q[ADDR_WIDTH-1:0];
               mem_wdata  = BIOS_BASE | 32'(boot_cnt_q);
               boot_cnt_d = boot_cnt_q + CW'(1);
            end
         end

         ST_LIVE: begin
            if (host_req) begin
               if (misaligned) begin
`ifdef MISALIGN_CHECK_EN
                  err_d = 1'b1;
`endif
               end else if (!WE) begin
                  mem_we = 1'b1;
               end else begin
                  data_out_d = mem[host_idx];
                  rd_valid_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // ---------------- control registers ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
`ifdef MISALIGN_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
`ifdef MISALIGN_CHECK_EN
         err_q      <= err_d;
`endif
      end
   end

   // ---------------- storage ----------------
   // Contents survive reset; the BIOS region is refreshed by the next boot.
   always_ff @(posedge clock) begin
      if (!reset && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_boot_memory_unit.sv
module tb_boot_memory_unit;

   localparam int BW = 16;
`ifdef MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] Address = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        CS = 1'b1;
   logic        WE = 1'b1;
   logic        OE = 1'b1;
   logic        rd_valid;
   logic        boot_done;
   logic [31:0] pc_in = '0;
   logic [31:0] pc_next;
   logic        err;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   // behavioural reference
   logic [31:0] m_mem [256];
   int          m_edges = 0;
   logic        m_done  = 1'b0;
   logic        m_rv    = 1'b0;
   logic        m_err   = 1'b0;
   logic [31:0] m_dout  = '0;

   boot_memory_unit #(.ADDR_WIDTH(8), .BIOS_WORDS(BW)) dut (
      .clock    (clock),
      .reset    (reset),
      .Address  (Address),
      .data_in  (data_in),
      .data_out (data_out),
      .CS       (CS),
      .WE       (WE),
      .OE       (OE),
      .rd_valid (rd_valid),
      .boot_done(boot_done),
      .pc_in    (pc_in),
      .pc_next  (pc_next),
      .err      (err)
   );

   always #10 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Drive inputs at the falling edge, return 1 time unit after the next rising edge.
   task automatic step(input logic rst, input logic cs, input logic we, input logic oe,
                       input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      reset   = rst;
      CS      = cs;
      WE      = we;
      OE      = oe;
      Address = a;
      data_in = d;
      pc_in   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] rand_addr(input logic [7:0] idx, input logic [1:0] low);
      logic [31:0] up;
      up = $urandom;
      return {up[21:0], idx, low};
   endfunction

   // Model: edges counted since reset release; boot word k lands at edge k,
   // host port opens from edge BW+1 on.
   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            m_edges = 0;
            m_done  = 1'b0;
            m_rv    = 1'b0;
            m_err   = 1'b0;
            m_dout  = '0;
         end else begin
            m_rv  = 1'b0;
            m_err = 1'b0;
            if (m_edges < BW) m_mem[m_edges] = 32'hB105_0000 | 32'(m_edges);
            if (m_done && !CS && (!WE || !OE)) begin
               if (MIS_EN && Address[1:0] != 2'b00) m_err = 1'b1;
               else if (!WE) m_mem[Address[9:2]] = data_in;
               else begin
                  m_dout = m_mem[Address[9:2]];
                  m_rv   = 1'b1;
               end
            end
            if (m_edges >= BW) m_done = 1'b1;
            if (m_edges < 1000) m_edges++;
         end
      end
   end

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (chk_en) begin
            chk("boot_done", 32'(boot_done), 32'(m_done));
            chk("rd_valid",  32'(rd_valid),  32'(m_rv));
            chk("err",       32'(err),       32'(m_err));
            chk("data_out",  data_out,       m_dout);
            chk("pc_next",   pc_next,        pc_in + 32'd4);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  idx;
      logic [1:0]  low;
      logic        cs, we, oe;

      step(1, 1, 1, 1, 32'h0, 32'h0);
      step(1, 0, 1, 0, 32'h3C, 32'h0);
      chk_en = 1'b1;
      chk("rst_data_out",  data_out, 32'h0);
      chk("rst_rd_valid",  32'(rd_valid), 32'h0);
      chk("rst_boot_done", 32'(boot_done), 32'h0);
      chk("rst_err",       32'(err), 32'h0);

      // first boot, with host traffic that must be ignored
      for (int k = 0; k < BW; k++) begin
         idx = 8'($urandom_range(0, 31));
         step(0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, rand_addr(idx, 2'b00), $urandom);
      end
      chk("boot_done_16", 32'(boot_done), 32'h0);
      step(0, 1, 1, 1, 32'h0, 32'h0);
      chk("boot_done_17", 32'(boot_done), 32'h1);

      for (int i = 16; i < 32; i++) step(0, 0, 0, 1, 32'(i * 4), $urandom);

      step(0, 0, 1, 0, 32'h3C, 32'h0);
      chk("rd_3c", data_out, 32'hB105_000F);
      chk("rd_3c_valid", 32'(rd_valid), 32'h1);
      step(0, 1, 1, 1, 32'h0, 32'h0);
      chk("rd_valid_pulse", 32'(rd_valid), 32'h0);
      chk("rd_hold", data_out, 32'hB105_000F);

      step(0, 0, 0, 1, 32'h40, 32'hDEAD_BEEF);
      step(0, 0, 1, 0, 32'h40, 32'h0);
      chk("wr_rd_40", data_out, 32'hDEAD_BEEF);

      #2  pc_in = 32'h0;
      #1  chk("pc_0", pc_next, 32'h4);
      #1  pc_in = 32'h1C;
      #1  chk("pc_1c", pc_next, 32'h20);
      #1  pc_in = 32'hFFFF_FFFC;
      #1  chk("pc_wrap", pc_next, 32'h0);

      step(0, 0, 0, 0, 32'h44, 32'h0000_1234);
      chk("we_oe_no_rd", 32'(rd_valid), 32'h0);
      step(0, 0, 1, 0, 32'h44, 32'h0);
      chk("we_oe_rd", data_out, 32'h0000_1234);

      step(0, 0, 0, 1, 32'h41, 32'h5555_AAAA);
`ifdef MISALIGN_CHECK_EN
      chk("mis_err", 32'(err), 32'h1);
      step(0, 1, 1, 1, 32'h0, 32'h0);
      chk("mis_err_pulse", 32'(err), 32'h0);
      step(0, 0, 1, 0, 32'h40, 32'h0);
      chk("mis_mem_kept", data_out, 32'hDEAD_BEEF);
`else
      chk("mis_err_tied", 32'(err), 32'h0);
      step(0, 0, 1, 0, 32'h40, 32'h0);
      chk("mis_mem_written", data_out, 32'h5555_AAAA);
`endif

      // randomized traffic, aliased upper bits, occasional misalignment
      for (int n = 0; n < 600; n++) begin
         cs  = ($urandom_range(0, 7) == 0);
         we  = 1'($urandom_range(0, 1));
         oe  = 1'($urandom_range(0, 1));
         idx = 8'($urandom_range(0, 31));
         low = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         step(0, cs, we, oe, rand_addr(idx, low), $urandom);
      end

      // overwrite BIOS region, then reset mid-boot
      for (int i = 0; i < BW; i++) step(0, 0, 0, 1, 32'(i * 4), $urandom);
      step(1, 1, 1, 1, 32'h0, 32'h0);
      chk("rst2_boot_done", 32'(boot_done), 32'h0);
      for (int k = 0; k < 5; k++) step(0, 1, 1, 1, 32'h0, 32'h0);
      step(1, 1, 1, 1, 32'h0, 32'h0);
      for (int k = 0; k < BW; k++) begin
         idx = 8'($urandom_range(0, 15));
         step(0, 0, 0, 1, rand_addr(idx, 2'b00), $urandom);
      end
      chk("reboot_16", 32'(boot_done), 32'h0);
      step(0, 1, 1, 1, 32'h0, 32'h0);
      chk("reboot_17", 32'(boot_done), 32'h1);
      for (int k = 0; k < BW; k++) begin
         step(0, 0, 1, 0, rand_addr(8'(k), 2'b00), $urandom);
         chk("bios_word", data_out, 32'hB105_0000 | 32'(k));
      end

      step(0, 1, 1, 1, 32'h0, 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
